// File: rtl/cga_line_doubler.sv
// CGA scan-line doubler: captures each input line into one half of a ping-pong
// buffer and replays the previous line twice at double rate with a matching hsync.
module cga_line_doubler #(
    parameter int unsigned LINE_MAX = 1024,
    parameter int unsigned HS_START = 10'd720,
    parameter int unsigned HS_WIDTH = 10'd80
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_ce,
    input  logic       line_reset,
    input  logic [3:0] video,
    output logic [3:0] dbl_video,
    output logic       dbl_hsync,
    output logic       dbl_active
);

    localparam int PTR_W = $clog2(LINE_MAX);
    localparam int HS_W  = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LINE_MAX - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    // Sync window bounds carry one extra bit so HS_START+HS_WIDTH cannot wrap.
    localparam logic [HS_W-1:0]  HS_LO    = HS_W'(HS_START);
    localparam logic [HS_W-1:0]  HS_HI    = HS_W'(HS_START + HS_WIDTH);

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_PLAY = 1'b1
    } rd_state_e;

    // Writer side
    logic             bank_q, bank_d;
    logic [PTR_W-1:0] wr_x_q, wr_x_d;
    logic [PTR_W-1:0] len_q, len_d;
    logic             wr_en;
    logic [PTR_W:0]   wr_addr;

    // Reader side
    rd_state_e        state_q, state_d;
    logic [PTR_W-1:0] rd_x_q, rd_x_d;
    logic             pass_q, pass_d;
    logic [PTR_W:0]   rd_addr;

    // Output pipeline: stage 1 aligns with the RAM read, stage 2 is the output register
    logic [3:0]       ram_q;
    logic             act1_q, act1_d;
    logic             hs1_q, hs1_d;
    logic [3:0]       video_q, video_d;
    logic             hs_q, hs_d;
    logic             act_q, act_d;

    logic [3:0]       mem [2*LINE_MAX];

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        bank_d  = bank_q;
        wr_x_d  = wr_x_q;
        len_d   = len_q;
        wr_en   = pix_ce;
        wr_addr = {bank_q, wr_x_q};
        if (line_reset) begin
            // A pixel coinciding with line_reset opens the new line at address 0.
            bank_d  = ~bank_q;
            len_d   = wr_x_q;
            wr_addr = {~bank_q, {PTR_W{1'b0}}};
            wr_x_d  = pix_ce ? PTR_ONE : '0;
        end else if (pix_ce && (wr_x_q != PTR_LAST)) begin
            wr_x_d = wr_x_q + PTR_ONE;
        end
    end

    always_comb begin
        state_d = state_q;
        rd_x_d  = rd_x_q;
        pass_d  = pass_q;
        if (line_reset) begin
            rd_x_d  = '0;
            pass_d  = 1'b0;
            state_d = (wr_x_q == '0) ? RD_IDLE : RD_PLAY;
        end else begin
            case (state_q)
                RD_IDLE: begin
                    rd_x_d = '0;
                    pass_d = 1'b0;
                end
                RD_PLAY: begin
                    if (rd_x_q == len_q - PTR_ONE) begin
                        rd_x_d = '0;
                        if (pass_q) begin
                            pass_d  = 1'b0;
                            state_d = RD_IDLE;
                        end else begin
                            pass_d = 1'b1;
                        end
                    end else begin
                        rd_x_d = rd_x_q + PTR_ONE;
                    end
                end
                default: state_d = RD_IDLE;
            endcase
        end
    end

    assign rd_addr = {~bank_q, rd_x_q};

    always_comb begin
        act1_d  = (state_q == RD_PLAY);
        hs1_d   = (state_q == RD_PLAY) &&
                  ({1'b0, rd_x_q} >= HS_LO) && ({1'b0, rd_x_q} < HS_HI);
        video_d = act1_q ? ram_q : 4'h0;
        hs_d    = hs1_q;
        act_d   = act1_q;
    end

    // NOTE: the line buffers carry no reset; nothing reads them until a non-zero len is latched.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= video;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q  <= 1'b0;
            wr_x_q  <= '0;
            len_q   <= '0;
            state_q <= RD_IDLE;
            rd_x_q  <= '0;
            pass_q  <= 1'b0;
            ram_q   <= 4'h0;
            act1_q  <= 1'b0;
            hs1_q   <= 1'b0;
            video_q <= 4'h0;
            hs_q    <= 1'b0;
            act_q   <= 1'b0;
        end else begin
            bank_q  <= bank_d;
            wr_x_q  <= wr_x_d;
            len_q   <= len_d;
            state_q <= state_d;
            rd_x_q  <= rd_x_d;
            pass_q  <= pass_d;
            ram_q   <= mem[rd_addr];
            act1_q  <= act1_d;
            hs1_q   <= hs1_d;
            video_q <= video_d;
            hs_q    <= hs_d;
            act_q   <= act_d;
        end
    end

    assign dbl_video  = video_q;
    assign dbl_hsync  = hs_q;
    assign dbl_active = act_q;

endmodule
